// File: rtl/bottle_tally_if.sv
// Bundle of the bottle_tally control, target and status signals.
// Master side drives run/clear/pulse/target and observes tally and flags.
// Slave side is the counter itself; no handshake, every signal is level or single-cycle.
interface bottle_tally_if #(
    parameter int DIGITS = 2
);
    logic                  isWork;
    logic                  clr;
    logic                  bot_done;
    logic [4*DIGITS-1:0]   bot_max;
    logic [4*DIGITS-1:0]   bot_seq;
    logic                  allFull;
    logic                  full_pulse;
    logic                  extra;
    logic                  bad_max;

    modport master (
        output isWork, clr, bot_done, bot_max,
        input  bot_seq, allFull, full_pulse, extra, bad_max
    );

    modport slave (
        input  isWork, clr, bot_done, bot_max,
        output bot_seq, allFull, full_pulse, extra, bad_max
    );
endinterface

// File: rtl/bottle_tally.sv
// BCD bottle-fill tally with target compare, full flag/event, over-fill and bad-target reporting.
// Latency: bot_done at edge N updates bot_seq, allFull and full_pulse at edge N; bad_max lags bot_max by one cycle.
// No backpressure: pulses arriving while paused/idle are dropped, pulses while full only raise extra.
module bottle_tally #(
    parameter int DIGITS = 2
) (
    input  logic           CLK,
    input  logic           RST_N,
    bottle_tally_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   seq_q, seq_d;
    logic [W-1:0]   seq_inc;
    logic           full_pulse_q, full_pulse_d;
    logic           extra_q, extra_d;
    logic           bad_max_q;
    logic           tmax_ok;
    logic           run_ok;
    logic           reached;

    // BCD +1 with ripple carry; 9 rolls to 0 and carries into the next digit.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Target is usable only when every digit is decimal and the value is non-zero.
    always_comb begin
        tmax_ok = (bus.bot_max != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bot_max[4*i +: 4] > 4'd9) begin
                tmax_ok = 1'b0;
            end
        end
    end

    // Packed BCD compares like binary once both operands hold valid digits.
    assign run_ok  = bus.isWork && tmax_ok;
    assign reached = (seq_q >= bus.bot_max);
    assign seq_inc = bcd_inc(seq_q);

    // Next-state, tally update and one-cycle event generation.
    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        full_pulse_d = 1'b0;
        extra_d      = 1'b0;
        if (bus.clr) begin
            seq_d   = '0;
            state_d = run_ok ? S_COUNT : S_IDLE;
        end else if (!run_ok) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = reached ? S_FULL : S_COUNT;
                end
                S_COUNT: begin
                    if (reached) begin
                        // Target was lowered below the tally: keep the count, declare full.
                        state_d      = S_FULL;
                        full_pulse_d = 1'b1;
                    end else if (bus.bot_done) begin
                        seq_d = seq_inc;
                        if (seq_inc == bus.bot_max) begin
                            state_d      = S_FULL;
                            full_pulse_d = 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    extra_d = bus.bot_done;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, tally and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            seq_q        <= '0;
            full_pulse_q <= 1'b0;
            extra_q      <= 1'b0;
            bad_max_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            full_pulse_q <= full_pulse_d;
            extra_q      <= extra_d;
            bad_max_q    <= !tmax_ok;
        end
    end

    assign bus.bot_seq    = seq_q;
    assign bus.allFull    = (state_q == S_FULL);
    assign bus.full_pulse = full_pulse_q;
    assign bus.extra      = extra_q;
    assign bus.bad_max    = bad_max_q;
endmodule

// File: tb/tb_bottle_tally.sv
// Bench for bottle_tally: a 2-digit and a 3-digit instance share one stimulus stream
// and are each checked every cycle against an integer-arithmetic reference model.
module tb_bottle_tally;
    logic        CLK;
    logic        RST_N;
    logic        work, clr, done;
    logic [15:0] mx;

    int checks;
    int errors;

    bottle_tally_if #(.DIGITS(2)) if2 ();
    bottle_tally_if #(.DIGITS(3)) if3 ();

    assign if2.isWork   = work;
    assign if2.clr      = clr;
    assign if2.bot_done = done;
    assign if2.bot_max  = mx[7:0];
    assign if3.isWork   = work;
    assign if3.clr      = clr;
    assign if3.bot_done = done;
    assign if3.bot_max  = mx[11:0];

    bottle_tally #(.DIGITS(2)) u2 (.CLK(CLK), .RST_N(RST_N), .bus(if2));
    bottle_tally #(.DIGITS(3)) u3 (.CLK(CLK), .RST_N(RST_N), .bus(if3));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: tally as an integer, mode 0 = idle, 1 = counting, 2 = full.
    int dg      [2] = '{2, 3};
    int m_tally [2];
    int m_mode  [2];
    bit m_pulse [2];
    bit m_extra [2];
    bit m_bad   [2];

    // Decimal value of an nd-digit BCD word, or -1 when any digit exceeds 9.
    function automatic int bcd_val(input logic [15:0] v, input int nd);
        int   val;
        logic [15:0] t;
        val = 0;
        t   = v;
        for (int i = nd - 1; i >= 0; i--) begin
            if (t[4*i +: 4] > 4'd9) return -1;
            val = val * 10 + int'(t[4*i +: 4]);
        end
        return val;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int          x;
        r = '0;
        x = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_tally[i] = 0; m_mode[i] = 0;
            m_pulse[i] = 0; m_extra[i] = 0; m_bad[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int tgt;
            bit ok;
            tgt = bcd_val(mx, dg[i]);
            ok  = (tgt > 0);
            m_bad[i]   = !ok;
            m_pulse[i] = 0;
            m_extra[i] = 0;
            if (clr) begin
                m_tally[i] = 0;
                m_mode[i]  = (work && ok) ? 1 : 0;
            end else if (!(work && ok)) begin
                m_mode[i] = 0;
            end else if (m_mode[i] == 0) begin
                m_mode[i] = (m_tally[i] >= tgt) ? 2 : 1;
            end else if (m_mode[i] == 1) begin
                if (m_tally[i] >= tgt) begin
                    m_mode[i] = 2; m_pulse[i] = 1;
                end else if (done) begin
                    m_tally[i]++;
                    if (m_tally[i] == tgt) begin
                        m_mode[i] = 2; m_pulse[i] = 1;
                    end
                end
            end else begin
                m_extra[i] = done;
            end
        end
    endtask

    function automatic logic [19:0] exp_vec(input int i);
        logic [15:0] s;
        s = to_bcd(m_tally[i]);
        return {s, (m_mode[i] == 2), m_pulse[i], m_extra[i], m_bad[i]};
    endfunction

    function automatic logic [19:0] act_vec(input int i);
        if (i == 0) return {8'h00, if2.bot_seq, if2.allFull, if2.full_pulse, if2.extra, if2.bad_max};
        return {4'h0, if3.bot_seq, if3.allFull, if3.full_pulse, if3.extra, if3.bad_max};
    endfunction

    // Apply one cycle of inputs (called just after a falling edge), advance the model
    // at the rising edge, and return at the next falling edge ready for sampling.
    task automatic cyc(input logic w, input logic c, input logic d, input logic [15:0] m);
        work = w; clr = c; done = d; mx = m;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        work = 0; clr = 0; done = 0; mx = 16'h0012;
        model_reset();
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_vec(i) !== 20'h0) begin
                errors++;
                $display("FAIL reset inst%0d: got %h expected %h", i, act_vec(i), 20'h0);
            end
        end
        RST_N = 1'b1;
    endtask

    task automatic test_count12();
        cyc(1, 1, 0, 16'h0012);
        for (int k = 0; k < 13; k++) begin
            cyc(1, 0, 1, 16'h0012);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL count12 inst%0d pulse%0d: got %h expected %h", i, k + 1, act_vec(i), exp_vec(i));
                end
            end
            if (k == 11) begin
                checks++;
                if ({if2.bot_seq, if2.allFull, if2.full_pulse} !== {8'h12, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL count12_full: got seq %h full %b pulse %b expected 12 1 1", if2.bot_seq, if2.allFull, if2.full_pulse);
                end
            end
        end
        checks++;
        if ({if2.bot_seq, if2.extra, if2.full_pulse} !== {8'h12, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL count12_extra: got seq %h extra %b pulse %b expected 12 1 0", if2.bot_seq, if2.extra, if2.full_pulse);
        end
    endtask

    task automatic test_pause();
        cyc(1, 1, 0, 16'h0100);
        for (int k = 0; k < 99; k++) begin
            cyc(1, 0, 1, 16'h0100);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL pause_count inst%0d pulse%0d: got %h expected %h", i, k + 1, act_vec(i), exp_vec(i));
                end
            end
        end
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, (k % 2 == 0), 16'h0100);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL pause_hold inst%0d cyc%0d: got %h expected %h", i, k, act_vec(i), exp_vec(i));
                end
            end
        end
        checks++;
        if (if3.bot_seq !== 12'h099) begin
            errors++;
            $display("FAIL pause_held: got %h expected 099", if3.bot_seq);
        end
        cyc(1, 0, 0, 16'h0100);
        cyc(1, 0, 1, 16'h0100);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_vec(i) !== exp_vec(i)) begin
                errors++;
                $display("FAIL pause_resume inst%0d: got %h expected %h", i, act_vec(i), exp_vec(i));
            end
        end
        checks++;
        if ({if3.bot_seq, if3.allFull} !== {12'h100, 1'b1}) begin
            errors++;
            $display("FAIL pause_full: got seq %h full %b expected 100 1", if3.bot_seq, if3.allFull);
        end
    endtask

    task automatic test_bad_max();
        logic [15:0] bad [2] = '{16'h001A, 16'h0000};
        cyc(1, 1, 0, 16'h0012);
        cyc(1, 0, 1, 16'h0012);
        cyc(1, 0, 1, 16'h0012);
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 3; k++) begin
                cyc(1, 0, 1, bad[b]);
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (act_vec(i) !== exp_vec(i)) begin
                        errors++;
                        $display("FAIL bad_max inst%0d max%h cyc%0d: got %h expected %h", i, bad[b], k, act_vec(i), exp_vec(i));
                    end
                end
            end
            checks++;
            if ({if2.bot_seq, if2.bad_max, if2.allFull} !== {8'h02, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL bad_max_flag max%h: got seq %h bad %b full %b expected 02 1 0", bad[b], if2.bot_seq, if2.bad_max, if2.allFull);
            end
        end
    endtask

    task automatic test_lower_target();
        cyc(1, 1, 0, 16'h0012);
        for (int k = 0; k < 8; k++) cyc(1, 0, 1, 16'h0012);
        cyc(1, 0, 0, 16'h0005);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_vec(i) !== exp_vec(i)) begin
                errors++;
                $display("FAIL lower_target inst%0d: got %h expected %h", i, act_vec(i), exp_vec(i));
            end
        end
        checks++;
        if ({if2.bot_seq, if2.allFull, if2.full_pulse} !== {8'h08, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL lower_target_flags: got seq %h full %b pulse %b expected 08 1 1", if2.bot_seq, if2.allFull, if2.full_pulse);
        end
    endtask

    task automatic test_clr_in_full();
        cyc(1, 0, 1, 16'h0005);
        cyc(1, 1, 1, 16'h0005);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_vec(i) !== exp_vec(i)) begin
                errors++;
                $display("FAIL clr_full inst%0d: got %h expected %h", i, act_vec(i), exp_vec(i));
            end
        end
        checks++;
        if ({if2.bot_seq, if2.allFull, if2.extra} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL clr_full_flags: got seq %h full %b extra %b expected 00 0 0", if2.bot_seq, if2.allFull, if2.extra);
        end
        cyc(1, 0, 1, 16'h0005);
        checks++;
        if (if2.bot_seq !== 8'h01) begin
            errors++;
            $display("FAIL clr_then_count: got %h expected 01", if2.bot_seq);
        end
    endtask

    task automatic test_async_reset();
        cyc(1, 1, 0, 16'h0012);
        for (int k = 0; k < 7; k++) cyc(1, 0, 1, 16'h0012);
        #2 RST_N = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_vec(i) !== 20'h0) begin
                errors++;
                $display("FAIL async_reset inst%0d: got %h expected %h", i, act_vec(i), 20'h0);
            end
        end
        work = 1; done = 1;
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 1, 16'h0012);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL after_reset inst%0d cyc%0d: got %h expected %h", i, k, act_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] m;
        m = 16'h0012;
        for (int k = 0; k < 600; k++) begin
            int r;
            r = $urandom_range(0, 39);
            if (r == 0)      m = 16'h00A3;
            else if (r == 1) m = 16'h0000;
            else if (r < 5)  m = to_bcd($urandom_range(1, 30));
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), m);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL random inst%0d cyc%0d: got %h expected %h", i, k, act_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_count12();
        test_pause();
        test_bad_max();
        test_lower_target();
        test_clr_in_full();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
